ls_sequencer: RTL

//  Multi-cycle load/store control FSM that sits directly upstream of the

---
 rtl/ls_sequencer_if.sv | 37 +++
 rtl/ls_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ls_sequencer_if.sv
// Request handshake plus datapath/data-memory control bundle for ls_sequencer.
// master = request source and datapath side, slave = the sequencer.
interface ls_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [15:0] req_imm;

    logic        D_En;
    logic [4:0]  D_Addr;
    logic [4:0]  S_Addr;
    logic [4:0]  T_Addr;
    logic [31:0] DT;
    logic        T_Sel;
    logic [4:0]  FS;
    logic        HILO_ld;
    logic [2:0]  Y_Sel;
    logic        dm_cs;
    logic        dm_wr;
    logic        dm_rd;
    logic        done;
    logic        busy;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_imm,
        input  req_ready, D_En, D_Addr, S_Addr, T_Addr, DT, T_Sel, FS,
               HILO_ld, Y_Sel, dm_cs, dm_wr, dm_rd, done, busy
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_imm,
        output req_ready, D_En, D_Addr, S_Addr, T_Addr, DT, T_Sel, FS,
               HILO_ld, Y_Sel, dm_cs, dm_wr, dm_rd, done, busy
    );
endinterface

// File: rtl/ls_sequencer.sv
// Purpose: lw/sw control FSM driving datapath and data-memory strobes (ADDR -> MEM -> WB).
// Latency: load done at E+2+MEM_WAIT, store done at E+1+MEM_WAIT (E = accept edge); Moore outputs.
// Backpressure: req_ready high only in IDLE, one request in flight; req_* sampled only on accept.
module ls_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter logic [4:0]  FS_ADD   = 5'h02,
    parameter logic [2:0]  YSEL_MEM = 3'd3,
    parameter logic [2:0]  YSEL_ALU = 3'd0
) (
    input  logic          clk,
    input  logic          reset,
    ls_sequencer_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_MEM, S_WB} state_t;

    typedef struct packed {
        logic        op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } req_t;

    typedef struct packed {
        logic        req_ready;
        logic        d_en;
        logic [4:0]  d_addr;
        logic [4:0]  s_addr;
        logic [4:0]  t_addr;
        logic [31:0] dt;
        logic        t_sel;
        logic [4:0]  fs;
        logic [2:0]  y_sel;
        logic        dm_cs;
        logic        dm_wr;
        logic        dm_rd;
        logic        done;
    } ctl_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);
    localparam ctl_t CTL_RST = '{req_ready: 1'b1, y_sel: YSEL_ALU, default: '0};

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    req_t       rq, rq_nxt;
    ctl_t       ctl, ctl_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            rq    <= '0;
            ctl   <= CTL_RST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rq    <= rq_nxt;
            ctl   <= ctl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rq_nxt    = rq;

        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt  = S_ADDR;
                    rq_nxt.op  = bus.req_op;
                    rq_nxt.rs  = bus.req_rs;
                    rq_nxt.rt  = bus.req_rt;
                    rq_nxt.imm = bus.req_imm;
                end
            end
            S_ADDR: begin
                state_nxt = S_MEM;
                cnt_nxt   = WAIT_INIT;
            end
            S_MEM: begin
                if (cnt == 4'd0) state_nxt = rq.op ? S_IDLE : S_WB;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered in that state.
        ctl_nxt        = '0;
        ctl_nxt.y_sel  = YSEL_ALU;
        ctl_nxt.s_addr = rq_nxt.rs;
        ctl_nxt.t_addr = rq_nxt.rt;
        ctl_nxt.d_addr = rq_nxt.rt;

        if (state_nxt == S_IDLE) begin
            ctl_nxt.req_ready = 1'b1;
        end else begin
            ctl_nxt.t_sel = 1'b1;
            ctl_nxt.dt    = {{16{rq_nxt.imm[15]}}, rq_nxt.imm};
            ctl_nxt.fs    = FS_ADD;
        end

        if (state_nxt == S_MEM) begin
            ctl_nxt.dm_cs = 1'b1;
            ctl_nxt.dm_rd = ~rq_nxt.op;
            ctl_nxt.dm_wr = rq_nxt.op;
            ctl_nxt.done  = rq_nxt.op && (cnt_nxt == 4'd0);
        end

        // R0 is hardwired: a load into rt==0 still runs but never writes.
        if (state_nxt == S_WB) begin
            ctl_nxt.dm_cs = 1'b1;
            ctl_nxt.dm_rd = 1'b1;
            ctl_nxt.y_sel = YSEL_MEM;
            ctl_nxt.d_en  = (rq_nxt.rt != 5'd0);
            ctl_nxt.done  = 1'b1;
        end
    end

    assign bus.req_ready = ctl.req_ready;
    assign bus.busy      = ~ctl.req_ready;
    assign bus.D_En      = ctl.d_en;
    assign bus.D_Addr    = ctl.d_addr;
    assign bus.S_Addr    = ctl.s_addr;
    assign bus.T_Addr    = ctl.t_addr;
    assign bus.DT        = ctl.dt;
    assign bus.T_Sel     = ctl.t_sel;
    assign bus.FS        = ctl.fs;
    assign bus.HILO_ld   = 1'b0;
    assign bus.Y_Sel     = ctl.y_sel;
    assign bus.dm_cs     = ctl.dm_cs;
    assign bus.dm_wr     = ctl.dm_wr;
    assign bus.dm_rd     = ctl.dm_rd;
    assign bus.done      = ctl.done;

endmodule
